tlb_op_ctrl: RTL and testbench
==============================

Name: tlb_op_ctrl

Overview:
Initiator side of the TLB maintenance interface. It holds the CP0 Index, EntryHi, EntryLo0 and EntryLo1 registers and sequences the TLBP, TLBR, TLBWI and TLBWR instructions. For each instruction it drives the TLB's search port 1, read port or write port. It sits between the WB-stage CP0 logic and the tlb instance; the MMU keeps search port 0.

Parameters:
TLBNUM, 16, number of TLB entries.
IDXW, $clog2(TLBNUM), width of an entry index.

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
op_valid  input  1  TLB instruction request
op_code  input  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
op_ready  output  1  request accepted when op_valid && op_ready
op_done  output  1  one-cycle completion pulse
c0_we  input  1  mtc0 write strobe
c0_addr  input  2  0 Index, 1 EntryHi, 2 EntryLo0, 3 EntryLo1
c0_wdata  input  32  mtc0 data
index_o, entryhi_o, entrylo0_o, entrylo1_o  output  32 each  register read values
s1_vpn2  output  19  search VPN2 = EntryHi[31:13]
s1_odd_page  output  1  constant 0
s1_asid  output  8  EntryHi[7:0]
s1_found  input  1  search hit
s1_index  input  IDXW  hit index
r_index  output  IDXW  Index[IDXW-1:0]
r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  input  19,8,1,20,3,1,1,20,3,1,1  read-port entry
we  output  1  TLB write enable
w_index  output  IDXW  write index
w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1  output  19,8,1,20,3,1,1,20,3,1,1  write-port entry

Behaviour:
- Register fields:
  - Index: P[31], idx[IDXW-1:0].
  - EntryHi: VPN2[31:13], ASID[7:0].
  - EntryLo0/1: PFN[25:6], C[5:3], D[2], V[1], G[0].
  - All other bits are read-only zero; writes to them are ignored.
- Reset (async, resetn=0):
  - All four registers are 0.
  - state=IDLE, op_ready=1, op_done=0, we=0.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: op_ready=1. On op_valid, latch op_code and go to EXEC.
  - EXEC, 1 cycle: performs the operation, then goes to DONE.
  - DONE, 1 cycle: op_done=1, op_ready=0, then goes to IDLE.
- Timing: accept at cycle T, execute at T+1, op_done at T+2, next accept earliest at T+3. Register results are visible at T+2.
- TLBP:
  - In EXEC, s1_* are driven from EntryHi; the s1_* outputs are driven from EntryHi in every state.
  - Hit: Index = {P=0, idx=s1_index}.
  - Miss: P=1, idx unchanged.
- TLBR:
  - In EXEC, r_index=Index.idx.
  - Captures EntryHi={r_vpn2,13'b0 pattern with ASID=r_asid}.
  - EntryLo0 = {r_pfn0, r_c0, r_d0, r_v0, r_g}; EntryLo1 likewise from the pfn1/c1/d1/v1 fields, with G=r_g.
- TLBWI:
  - we=1 for exactly the EXEC cycle; w_index=Index.idx.
  - w_vpn2/w_asid come from EntryHi.
  - pfn/c/d/v come from each EntryLo.
  - w_g = EntryLo0.G & EntryLo1.G.
- TLBWR: same as TLBWI, except w_index comes from Random (see Optional Feature).
- we is 0 in every state other than EXEC of a write op.
- c0 writes:
  - c0_we is accepted in any state.
  - If it coincides with an EXEC capture to the same register (Index for TLBP; EntryHi/EntryLo for TLBR), the op result wins.
  - A c0 write during EXEC of TLBWI/TLBWR does not affect the entry being written; w_* use register values at the start of EXEC.
- op_code is sampled only at acceptance; op_valid is ignored outside IDLE.
- Reset mid-operation (any state): immediate return to IDLE, we=0, op_done=0, no partial register update.

Optional Feature:
- Macro: TLB_RANDOM_EN.
- Defined:
  - An internal IDXW-bit Random register, reset to TLBNUM-1.
  - Decrements every cycle and wraps from 0 to TLBNUM-1.
  - TLBWR uses its value at the EXEC cycle as w_index.
- Undefined: no Random register; TLBWR behaves exactly as TLBWI (w_index=Index.idx).

Test Plan:
1. Write-port field mapping: after reset, c0 writes Index=3, EntryHi=0x0002_400A, EntryLo0=0x0000_1017, EntryLo1=0x0000_2016, then TLBWI.
   - Required: single-cycle we=1, w_index=3, w_vpn2=0x12, w_asid=0x0A.
   - Required: w_pfn0=0x40, c0=2, d0=1, v0=1; w_pfn1=0x80, c1=2, d1=1, v1=1; w_g=0.
2. TLBP hit then miss:
   - EntryHi=0x0002_400A with s1_found=1, s1_index=3 → index_o=0x0000_0003 at op_done.
   - Then s1_found=0 → index_o=0x8000_0003.
3. TLBR with Index=5 and r_vpn2=0x7, r_asid=0x22, r_g=1, r_pfn0=0x1, r_c0=3, r_d0=0, r_v0=1:
   - Required: r_index=5 in EXEC, entryhi_o=0x0000_E022, entrylo0_o=0x0000_005B, entrylo1_o bit0=1.
4. op_valid held high with TLBWI:
   - Required: accepts 3 cycles apart, op_ready low for 2 cycles after each accept, exactly one we pulse and one op_done pulse per op.
5. c0 write of Index=0x9 in the TLBP EXEC cycle with a hit at index 2 → index_o=0x0000_0002.
6. resetn low during the EXEC cycle of TLBWI → we falls immediately; after release op_ready=1 and all registers read 0.
   - With TLB_RANDOM_EN: TLBWR accepted at cycle 10 after reset release uses w_index=(15-11) mod 16 = 4.

Source files
------------

// File: rtl/tlb_op_ctrl_if.sv
// Bundle between the CP0 side, the TLB maintenance sequencer and the TLB's search port 1,
// read port and write port. The sequencer uses the slave modport; the environment uses master.
interface tlb_op_ctrl_if #(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned IDXW   = $clog2(TLBNUM)
);
    // Instruction handshake
    logic            op_valid;
    logic [1:0]      op_code;
    logic            op_ready;
    logic            op_done;

    // mtc0 write port and register read values
    logic            c0_we;
    logic [1:0]      c0_addr;
    logic [31:0]     c0_wdata;
    logic [31:0]     index_o;
    logic [31:0]     entryhi_o;
    logic [31:0]     entrylo0_o;
    logic [31:0]     entrylo1_o;

    // TLB search port 1
    logic [18:0]     s1_vpn2;
    logic            s1_odd_page;
    logic [7:0]      s1_asid;
    logic            s1_found;
    logic [IDXW-1:0] s1_index;

    // TLB read port
    logic [IDXW-1:0] r_index;
    logic [18:0]     r_vpn2;
    logic [7:0]      r_asid;
    logic            r_g;
    logic [19:0]     r_pfn0;
    logic [2:0]      r_c0;
    logic            r_d0;
    logic            r_v0;
    logic [19:0]     r_pfn1;
    logic [2:0]      r_c1;
    logic            r_d1;
    logic            r_v1;

    // TLB write port
    logic            we;
    logic [IDXW-1:0] w_index;
    logic [18:0]     w_vpn2;
    logic [7:0]      w_asid;
    logic            w_g;
    logic [19:0]     w_pfn0;
    logic [2:0]      w_c0;
    logic            w_d0;
    logic            w_v0;
    logic [19:0]     w_pfn1;
    logic [2:0]      w_c1;
    logic            w_d1;
    logic            w_v1;

    modport slave (
        input  op_valid, op_code, c0_we, c0_addr, c0_wdata,
        input  s1_found, s1_index,
        input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
        output op_ready, op_done, index_o, entryhi_o, entrylo0_o, entrylo1_o,
        output s1_vpn2, s1_odd_page, s1_asid, r_index,
        output we, w_index, w_vpn2, w_asid, w_g,
        output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1
    );

    modport master (
        output op_valid, op_code, c0_we, c0_addr, c0_wdata,
        output s1_found, s1_index,
        output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
        input  op_ready, op_done, index_o, entryhi_o, entrylo0_o, entrylo1_o,
        input  s1_vpn2, s1_odd_page, s1_asid, r_index,
        input  we, w_index, w_vpn2, w_asid, w_g,
        input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: owns CP0 Index/EntryHi/EntryLo0/EntryLo1 and runs TLBP/TLBR/TLBWI/TLBWR.
// Define TLB_RANDOM_EN to add the Random register that supplies the TLBWR write index.
module tlb_op_ctrl #(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    tlb_op_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    localparam logic [1:0] OpTlbp  = 2'b00;
    localparam logic [1:0] OpTlbr  = 2'b01;
    localparam logic [1:0] OpTlbwi = 2'b10;
    localparam logic [1:0] OpTlbwr = 2'b11;

    localparam logic [1:0] AddrIndex = 2'd0;
    localparam logic [1:0] AddrHi    = 2'd1;
    localparam logic [1:0] AddrLo0   = 2'd2;
    localparam logic [1:0] AddrLo1   = 2'd3;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;

    // Only the architecturally writable fields are stored; everything else reads as zero.
    logic            idx_p_q, idx_p_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [18:0]     vpn2_q, vpn2_d;
    logic [7:0]      asid_q, asid_d;
    logic [25:0]     lo0_q, lo0_d;
    logic [25:0]     lo1_q, lo1_d;

    logic            in_exec;
    assign in_exec = (state_q == StExec);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            StIdle: begin
                if (bus.op_valid) begin
                    op_d    = bus.op_code;
                    state_d = StExec;
                end
            end
            StExec:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            op_q    <= OpTlbp;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // ------------------------------------------------------------------
    // CP0 registers: mtc0 first, then the EXEC capture overrides it
    // ------------------------------------------------------------------
    always_comb begin
        idx_p_d = idx_p_q;
        idx_d   = idx_q;
        vpn2_d  = vpn2_q;
        asid_d  = asid_q;
        lo0_d   = lo0_q;
        lo1_d   = lo1_q;

        if (bus.c0_we) begin
            case (bus.c0_addr)
                AddrIndex: begin
                    idx_p_d = bus.c0_wdata[31];
                    idx_d   = bus.c0_wdata[IDXW-1:0];
                end
                AddrHi: begin
                    vpn2_d = bus.c0_wdata[31:13];
                    asid_d = bus.c0_wdata[7:0];
                end
                AddrLo0: lo0_d = bus.c0_wdata[25:0];
                AddrLo1: lo1_d = bus.c0_wdata[25:0];
                default: ;
            endcase
        end

        if (in_exec) begin
            case (op_q)
                OpTlbp: begin
                    // A miss keeps the previous index, not a same-cycle mtc0 value.
                    if (bus.s1_found) begin
                        idx_p_d = 1'b0;
                        idx_d   = bus.s1_index;
                    end else begin
                        idx_p_d = 1'b1;
                        idx_d   = idx_q;
                    end
                end
                OpTlbr: begin
                    vpn2_d = bus.r_vpn2;
                    asid_d = bus.r_asid;
                    lo0_d  = {bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0, bus.r_g};
                    lo1_d  = {bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1, bus.r_g};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_p_q <= 1'b0;
            idx_q   <= '0;
            vpn2_q  <= '0;
            asid_q  <= '0;
            lo0_q   <= '0;
            lo1_q   <= '0;
        end else begin
            idx_p_q <= idx_p_d;
            idx_q   <= idx_d;
            vpn2_q  <= vpn2_d;
            asid_q  <= asid_d;
            lo0_q   <= lo0_d;
            lo1_q   <= lo1_d;
        end
    end

    // ------------------------------------------------------------------
    // Write index source
    // ------------------------------------------------------------------
    logic [IDXW-1:0] wr_index;

`ifdef TLB_RANDOM_EN
    logic [IDXW-1:0] random_q, random_d;

    always_comb begin
        random_d = (random_q == '0) ? IDXW'(TLBNUM - 1) : random_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random_q <= IDXW'(TLBNUM - 1);
        end else begin
            random_q <= random_d;
        end
    end

    assign wr_index = (op_q == OpTlbwr) ? random_q : idx_q;
`else
    assign wr_index = idx_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.op_ready   = (state_q == StIdle);
    assign bus.op_done    = (state_q == StDone);

    assign bus.index_o    = {idx_p_q, {(31 - IDXW){1'b0}}, idx_q};
    assign bus.entryhi_o  = {vpn2_q, 5'b0, asid_q};
    assign bus.entrylo0_o = {6'b0, lo0_q};
    assign bus.entrylo1_o = {6'b0, lo1_q};

    assign bus.s1_vpn2     = vpn2_q;
    assign bus.s1_odd_page = 1'b0;
    assign bus.s1_asid     = asid_q;

    assign bus.r_index = idx_q;

    // Write port reflects register state at the start of EXEC; an mtc0 in EXEC lands afterwards.
    assign bus.we      = in_exec && (op_q == OpTlbwi || op_q == OpTlbwr);
    assign bus.w_index = wr_index;
    assign bus.w_vpn2  = vpn2_q;
    assign bus.w_asid  = asid_q;
    assign bus.w_g     = lo0_q[0] & lo1_q[0];
    assign bus.w_pfn0  = lo0_q[25:6];
    assign bus.w_c0    = lo0_q[5:3];
    assign bus.w_d0    = lo0_q[2];
    assign bus.w_v0    = lo0_q[1];
    assign bus.w_pfn1  = lo1_q[25:6];
    assign bus.w_c1    = lo1_q[5:3];
    assign bus.w_d1    = lo1_q[2];
    assign bus.w_v1    = lo1_q[1];

    logic unused_wdata;
    assign unused_wdata = ^bus.c0_wdata[30:26];

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    we_only_in_exec: assert property (@(posedge clk) disable iff (!resetn)
        bus.we |-> state_q == StExec);

    done_is_pulse: assert property (@(posedge clk) disable iff (!resetn)
        bus.op_done |=> !bus.op_done);

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: register field table, op sequences, back-to-back and reset cases.
// The Random-index case is exercised when TLB_RANDOM_EN is defined.
module tb_tlb_op_ctrl;

    localparam int unsigned TLBNUM = 16;
    localparam int unsigned IDXW   = 4;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    tlb_op_ctrl_if #(.TLBNUM(TLBNUM)) bus ();

    tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } c0_vec_t;

    c0_vec_t    c0_tab [6];
    logic [2:0] hold_exp [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] read_reg(input logic [1:0] addr);
        case (addr)
            2'd0:    return bus.index_o;
            2'd1:    return bus.entryhi_o;
            2'd2:    return bus.entrylo0_o;
            default: return bus.entrylo1_o;
        endcase
    endfunction

    task automatic c0_write(input logic [1:0] addr, input logic [31:0] data);
        bus.c0_we    = 1'b1;
        bus.c0_addr  = addr;
        bus.c0_wdata = data;
        tick();
        bus.c0_we    = 1'b0;
    endtask

    // Leaves the DUT in its EXEC cycle, sampled #1 after the accepting edge.
    task automatic start_op(input logic [1:0] code);
        chk("op_ready before accept", 32'(bus.op_ready), 32'd1);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        tick();
        bus.op_valid = 1'b0;
    endtask

    initial begin
        c0_tab[0] = '{"index all ones",   2'd0, 32'hFFFF_FFFF, 32'h8000_000F};
        c0_tab[1] = '{"entryhi all ones", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_E0FF};
        c0_tab[2] = '{"entrylo0 all ones", 2'd2, 32'hFFFF_FFFF, 32'h03FF_FFFF};
        c0_tab[3] = '{"entrylo1 all ones", 2'd3, 32'hFFFF_FFFF, 32'h03FF_FFFF};
        c0_tab[4] = '{"index no P",       2'd0, 32'h7FFF_FFF5, 32'h0000_0005};
        c0_tab[5] = '{"entryhi pattern",  2'd1, 32'h1234_5678, 32'h1234_4078};
        hold_exp[0] = 3'b100;
        hold_exp[1] = 3'b010;
        hold_exp[2] = 3'b001;

        resetn       = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_code  = 2'b00;
        bus.c0_we    = 1'b0;
        bus.c0_addr  = 2'd0;
        bus.c0_wdata = '0;
        bus.s1_found = 1'b0;
        bus.s1_index = '0;
        bus.r_vpn2   = '0;
        bus.r_asid   = '0;
        bus.r_g      = 1'b0;
        bus.r_pfn0   = '0;
        bus.r_c0     = '0;
        bus.r_d0     = 1'b0;
        bus.r_v0     = 1'b0;
        bus.r_pfn1   = '0;
        bus.r_c1     = '0;
        bus.r_d1     = 1'b0;
        bus.r_v1     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Reset state
        chk("reset op_ready", 32'(bus.op_ready), 32'd1);
        chk("reset op_done", 32'(bus.op_done), 32'd0);
        chk("reset we", 32'(bus.we), 32'd0);
        chk("reset index", bus.index_o, 32'h0);
        chk("reset entryhi", bus.entryhi_o, 32'h0);
        chk("reset entrylo0", bus.entrylo0_o, 32'h0);
        chk("reset entrylo1", bus.entrylo1_o, 32'h0);

        // Field masking of mtc0 writes
        for (int i = 0; i < 6; i++) begin
            c0_write(c0_tab[i].addr, c0_tab[i].wdata);
            chk(c0_tab[i].name, read_reg(c0_tab[i].addr), c0_tab[i].exp);
        end

        // TLBWI write-port mapping
        c0_write(2'd0, 32'h0000_0003);
        c0_write(2'd1, 32'h0002_400A);
        c0_write(2'd2, 32'h0000_1017);
        c0_write(2'd3, 32'h0000_2016);
        start_op(2'b10);
        chk("tlbwi we", 32'(bus.we), 32'd1);
        chk("tlbwi w_index", 32'(bus.w_index), 32'd3);
        chk("tlbwi w_vpn2", 32'(bus.w_vpn2), 32'h12);
        chk("tlbwi w_asid", 32'(bus.w_asid), 32'h0A);
        chk("tlbwi w_pfn0", 32'(bus.w_pfn0), 32'h40);
        chk("tlbwi c0/d0/v0", 32'({bus.w_c0, bus.w_d0, bus.w_v0}), 32'b010_1_1);
        chk("tlbwi w_pfn1", 32'(bus.w_pfn1), 32'h80);
        chk("tlbwi c1/d1/v1", 32'({bus.w_c1, bus.w_d1, bus.w_v1}), 32'b010_1_1);
        chk("tlbwi w_g", 32'(bus.w_g), 32'd0);
        chk("tlbwi op_ready in exec", 32'(bus.op_ready), 32'd0);
        tick();
        chk("tlbwi we after exec", 32'(bus.we), 32'd0);
        chk("tlbwi op_done", 32'(bus.op_done), 32'd1);
        tick();
        chk("tlbwi op_done clears", 32'(bus.op_done), 32'd0);

        // TLBP hit, then miss
        c0_write(2'd0, 32'h0000_000C);
        bus.s1_found = 1'b1;
        bus.s1_index = 4'd3;
        start_op(2'b00);
        chk("tlbp s1_vpn2", 32'(bus.s1_vpn2), 32'h12);
        chk("tlbp s1_asid", 32'(bus.s1_asid), 32'h0A);
        chk("tlbp s1_odd_page", 32'(bus.s1_odd_page), 32'd0);
        chk("tlbp no write", 32'(bus.we), 32'd0);
        tick();
        chk("tlbp hit index", bus.index_o, 32'h0000_0003);
        tick();
        bus.s1_found = 1'b0;
        start_op(2'b00);
        tick();
        chk("tlbp miss index", bus.index_o, 32'h8000_0003);
        tick();

        // TLBR
        c0_write(2'd0, 32'h0000_0005);
        bus.r_vpn2 = 19'h7;
        bus.r_asid = 8'h22;
        bus.r_g    = 1'b1;
        bus.r_pfn0 = 20'h1;
        bus.r_c0   = 3'd3;
        bus.r_d0   = 1'b0;
        bus.r_v0   = 1'b1;
        bus.r_pfn1 = 20'h2;
        bus.r_c1   = 3'd1;
        bus.r_d1   = 1'b1;
        bus.r_v1   = 1'b0;
        start_op(2'b01);
        chk("tlbr r_index", 32'(bus.r_index), 32'd5);
        tick();
        chk("tlbr op_done", 32'(bus.op_done), 32'd1);
        chk("tlbr entryhi", bus.entryhi_o, 32'h0000_E022);
        chk("tlbr entrylo0", bus.entrylo0_o, 32'h0000_005B);
        chk("tlbr entrylo1", bus.entrylo1_o, 32'h0000_008D);
        tick();

        // op_valid held high: accept every third cycle, one we and one op_done per op
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b10;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("hold ready/we/done cycle %0d", i),
                32'({bus.op_ready, bus.we, bus.op_done}), 32'(hold_exp[i % 3]));
            tick();
        end
        bus.op_valid = 1'b0;
        chk("hold back to idle", 32'(bus.op_ready), 32'd1);

        // mtc0 Index in TLBP EXEC loses to the hit
        bus.s1_found = 1'b1;
        bus.s1_index = 4'd2;
        start_op(2'b00);
        bus.c0_we    = 1'b1;
        bus.c0_addr  = 2'd0;
        bus.c0_wdata = 32'h0000_0009;
        tick();
        bus.c0_we    = 1'b0;
        chk("tlbp beats mtc0", bus.index_o, 32'h0000_0002);
        tick();

        // Reset asserted during TLBWI EXEC
        c0_write(2'd0, 32'h0000_0003);
        start_op(2'b10);
        chk("pre-reset we", 32'(bus.we), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid-reset we", 32'(bus.we), 32'd0);
        chk("mid-reset op_done", 32'(bus.op_done), 32'd0);
        chk("mid-reset op_ready", 32'(bus.op_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("post-reset op_ready", 32'(bus.op_ready), 32'd1);
        chk("post-reset index", bus.index_o, 32'h0);
        chk("post-reset entryhi", bus.entryhi_o, 32'h0);
        chk("post-reset entrylo0", bus.entrylo0_o, 32'h0);
        chk("post-reset entrylo1", bus.entrylo1_o, 32'h0);

`ifdef TLB_RANDOM_EN
        // Random reads 15 until the first edge after release, then counts down each cycle.
        repeat (10) @(posedge clk);
        #1;
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b11;
        tick();
        bus.op_valid = 1'b0;
        chk("tlbwr we", 32'(bus.we), 32'd1);
        chk("tlbwr random index", 32'(bus.w_index), 32'd4);
        tick();
        tick();
`else
        tick();
        c0_write(2'd0, 32'h0000_0007);
        start_op(2'b11);
        chk("tlbwr we", 32'(bus.we), 32'd1);
        chk("tlbwr uses index", 32'(bus.w_index), 32'd7);
        tick();
        chk("tlbwr op_done", 32'(bus.op_done), 32'd1);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
